// File: rtl/lc3_memaccess_ctrl_pkg.sv
// Shared types and helpers for the LC3 MemAccess sequencing controller.
//   mem_op_t    : LD, ST, LDI, STI request encodings
//   mem_state_t : controller FSM states
//   is_load / is_indirect : op classification helpers
package memaccess_ctrl_pkg_hdl;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        LD  = 2'd0,
        ST  = 2'd1,
        LDI = 2'd2,
        STI = 2'd3
    } mem_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IND  = 2'd1,
        ACC  = 2'd2,
        RSP  = 2'd3
    } mem_state_t;

    function automatic logic is_load(mem_op_t op);
        return (op == LD) || (op == LDI);
    endfunction

    function automatic logic is_indirect(mem_op_t op);
        return (op == LDI) || (op == STI);
    endfunction

endpackage

// File: rtl/lc3_memaccess_ctrl_wdog.sv
// Ack watchdog for one memory access.
//   clock, reset : clock, async active-high reset
//   clear        : restart the count (new access begins)
//   active       : an access is outstanding (data_req)
//   ack          : access completed this cycle
//   expire       : TIMEOUT cycles elapsed without ack (this is the last one)
// TIMEOUT=0 removes the counter entirely and expire is tied low.
module memaccess_wdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic active,
    input  logic ack,
    output logic expire
);

    generate
        if (TIMEOUT > 0) begin : g_wdog
            localparam int CW = $clog2(TIMEOUT + 1);
            logic [CW-1:0] wait_cnt;

            always_ff @(posedge clock or posedge reset) begin
                if (reset)
                    wait_cnt <= '0;
                else if (clear)
                    wait_cnt <= '0;
                else if (active && !ack)
                    wait_cnt <= wait_cnt + CW'(1);
            end

            // Fires in the TIMEOUT-th waiting cycle; a coincident ack wins.
            assign expire = active && !ack && (wait_cnt == CW'(TIMEOUT - 1));
        end else begin : g_nowdog
            assign expire = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/lc3_memaccess_ctrl.sv
// LC3 MemAccess sequencing controller.
// Accepts one LD/ST/LDI/STI request at a time, drives the data-memory port
// (expanding LDI/STI into pointer read + access), waits on data_ack with a
// watchdog, and presents the load result on memout until rsp_ready.
//   req_*  : request handshake from pipeline controller
//   data_* : data-memory port (data_req/data_rd/data_addr/data_din out,
//            data_dout/data_ack in)
//   rsp_*  : response handshake; rsp_err flags a watchdog abort
//   memout : load result, 0 for stores and aborted requests
module lc3_memaccess_ctrl
    import memaccess_ctrl_pkg_hdl::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              data_req,
    output logic              data_rd,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_din,
    input  logic [DATA_W-1:0] data_dout,
    input  logic              data_ack,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_err,
    output logic [DATA_W-1:0] memout
);

    mem_state_t        state, state_nxt;
    mem_op_t           op_q;
    mem_op_t           op_in;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              expire;
    logic              wd_clear;

    assign op_in = mem_op_t'(req_op);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Port outputs decode straight from state so reset drops data_req at once.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        data_req  = 1'b0;
        data_rd   = 1'b0;
        data_addr = '0;
        data_din  = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = is_indirect(op_in) ? IND : ACC;
            end
            IND: begin
                data_req  = 1'b1;
                data_rd   = 1'b1;
                data_addr = addr_q;
                if (data_ack)    state_nxt = ACC;
                else if (expire) state_nxt = RSP;
            end
            ACC: begin
                data_req  = 1'b1;
                data_rd   = is_load(op_q);
                data_addr = addr_q;
                if (!is_load(op_q)) data_din = data_q;
                if (data_ack || expire) state_nxt = RSP;
            end
            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Any state change restarts the watchdog, which covers entry to IND/ACC.
    assign wd_clear = (state_nxt != state);

    memaccess_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clock  (clock),
        .reset  (reset),
        .clear  (wd_clear),
        .active (data_req),
        .ack    (data_ack),
        .expire (expire)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_q    <= LD;
            addr_q  <= '0;
            data_q  <= '0;
            memout  <= '0;
            rsp_err <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    op_q   <= op_in;
                    addr_q <= req_addr;
                    data_q <= req_data;
                end
                IND: begin
                    // Pointer is used verbatim as the effective address.
                    if (data_ack) addr_q <= data_dout;
                    else if (expire) begin
                        memout  <= '0;
                        rsp_err <= 1'b1;
                    end
                end
                ACC: begin
                    if (data_ack) memout <= is_load(op_q) ? data_dout : '0;
                    else if (expire) begin
                        memout  <= '0;
                        rsp_err <= 1'b1;
                    end
                end
                RSP: if (rsp_ready) rsp_err <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lc3_memaccess_ctrl.sv
module tb_lc3_memaccess_ctrl;

    localparam int TO = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'd0;
    logic [15:0] req_addr = 16'h0;
    logic [15:0] req_data = 16'h0;
    logic        data_req;
    logic        data_rd;
    logic [15:0] data_addr;
    logic [15:0] data_din;
    logic [15:0] data_dout = 16'h0;
    logic        data_ack = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_err;
    logic [15:0] memout;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    lc3_memaccess_ctrl #(.TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_data(req_data),
        .data_req(data_req), .data_rd(data_rd), .data_addr(data_addr),
        .data_din(data_din), .data_dout(data_dout), .data_ack(data_ack),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_err(rsp_err),
        .memout(memout)
    );

    // ---------------- memory model ----------------
    logic [15:0] mem [int];

    function automatic logic [15:0] mrd(input logic [15:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return a ^ 16'h5A3C;
    endfunction

    // Responder: per-access ack delay (255 = never), access log, port hygiene.
    int          dly [2];
    int          acc_idx = 0;
    int          wcnt = 0;
    int          req_cycles = 0;
    int          viol = 0;
    logic        noise = 1'b0;
    logic        p_req = 1'b0, p_ack = 1'b0, p_rd = 1'b0;
    logic [15:0] p_addr = 16'h0, p_din = 16'h0;
    logic [15:0] log_addr [$];
    logic        log_rd   [$];
    logic [15:0] log_din  [$];
    time         last_accept = 0;

    always @(negedge clock) begin
        if (reset) begin
            data_ack = 1'b0;
            wcnt = 0;
            p_req = 1'b0;
            p_ack = 1'b0;
        end else if (data_req) begin
            req_cycles++;
            if (p_req && !p_ack && (data_addr !== p_addr || data_rd !== p_rd || data_din !== p_din))
                viol++;
            if (data_rd && data_din !== 16'h0) viol++;
            data_dout = mrd(data_addr);
            if (wcnt >= dly[(acc_idx < 2) ? acc_idx : 1]) begin
                data_ack = 1'b1;
                log_addr.push_back(data_addr);
                log_rd.push_back(data_rd);
                log_din.push_back(data_din);
                if (!data_rd) mem[int'(data_addr)] = data_din;
                acc_idx++;
                wcnt = 0;
            end else begin
                data_ack = 1'b0;
                wcnt++;
            end
            p_req = 1'b1; p_ack = data_ack;
            p_addr = data_addr; p_rd = data_rd; p_din = data_din;
        end else begin
            if (data_rd !== 1'b0 || data_addr !== 16'h0 || data_din !== 16'h0) viol++;
            data_ack  = noise ? 1'($urandom) : 1'b0;
            data_dout = 16'($urandom);
            wcnt = 0;
            p_req = 1'b0;
            p_ack = 1'b0;
        end
    end

    // One full request; caller is just past a negedge with the DUT idle.
    // op: 0=LD 1=ST 2=LDI 3=STI; d1 = pointer-read delay, d2 = access delay.
    task automatic run_req(input int op, input logic [15:0] addr, input logic [15:0] wdata,
                           input int d1, input int d2, input int rdy_dly);
        logic [15:0] eaddr [$];
        logic        erd   [$];
        logic [15:0] edin  [$];
        logic [15:0] emem, eff;
        logic        eerr;
        int          lat, n;
        bit          ind, ld;
        ind = (op >= 2);
        ld  = (op == 0) || (op == 2);
        eff = addr; eerr = 1'b0; lat = 1; emem = 16'h0;
        if (ind) begin
            if (d1 >= TO) begin eerr = 1'b1; lat += TO; end
            else begin
                eaddr.push_back(addr); erd.push_back(1'b1); edin.push_back(16'h0);
                eff = mrd(addr);
                lat += d1 + 1;
            end
        end
        if (!eerr) begin
            if (d2 >= TO) begin eerr = 1'b1; lat += TO; end
            else begin
                eaddr.push_back(eff); erd.push_back(ld); edin.push_back(ld ? 16'h0 : wdata);
                emem = ld ? mrd(eff) : 16'h0;
                lat += d2 + 1;
            end
        end
        if (eerr) emem = 16'h0;

        log_addr.delete(); log_rd.delete(); log_din.delete();
        req_cycles = 0; viol = 0; acc_idx = 0;
        if (ind) begin dly[0] = d1; dly[1] = d2; end
        else     begin dly[0] = d2; dly[1] = d2; end

        req_valid = 1'b1; req_op = 2'(op); req_addr = addr; req_data = wdata;
        @(posedge clock);
        last_accept = $time;
        @(negedge clock);
        n = 1;
        req_valid = noise ? 1'($urandom) : 1'b0;
        req_op = 2'($urandom); req_addr = 16'($urandom); req_data = 16'($urandom);
        while (!rsp_valid && n < 100) begin
            checks++;
            if (req_ready !== 1'b0) begin
                errors++; $display("FAIL busy_ready cyc=%0d got=%b want=0", n, req_ready);
            end
            @(negedge clock);
            n++;
            req_valid = noise ? 1'($urandom) : 1'b0;
        end
        req_valid = 1'b0;
        checks++;
        if (n !== lat) begin
            errors++; $display("FAIL latency op=%0d got=%0d want=%0d", op, n, lat);
        end
        for (int i = 0; i <= rdy_dly; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || memout !== emem || rsp_err !== eerr || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL rsp op=%0d hold=%0d got v=%b m=%h e=%b r=%b want v=1 m=%h e=%b r=0",
                         op, i, rsp_valid, memout, rsp_err, req_ready, emem, eerr);
            end
            if (i < rdy_dly) @(negedge clock);
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL post_rsp got ready=%b valid=%b err=%b want 1 0 0", req_ready, rsp_valid, rsp_err);
        end
        checks++;
        if (req_cycles !== lat - 1) begin
            errors++; $display("FAIL req_cycles op=%0d got=%0d want=%0d", op, req_cycles, lat - 1);
        end
        checks++;
        if (viol !== 0) begin
            errors++; $display("FAIL port_hygiene op=%0d got=%0d violations want=0", op, viol);
        end
        checks++;
        if (log_addr.size() !== eaddr.size()) begin
            errors++; $display("FAIL access_count op=%0d got=%0d want=%0d", op, log_addr.size(), eaddr.size());
        end else begin
            foreach (eaddr[i]) begin
                checks++;
                if (log_addr[i] !== eaddr[i] || log_rd[i] !== erd[i] || log_din[i] !== edin[i]) begin
                    errors++;
                    $display("FAIL access%0d op=%0d got a=%h rd=%b din=%h want a=%h rd=%b din=%h",
                             i, op, log_addr[i], log_rd[i], log_din[i], eaddr[i], erd[i], edin[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (req_ready !== 1'b1 || data_req !== 1'b0 || data_rd !== 1'b0 || rsp_valid !== 1'b0 ||
            rsp_err !== 1'b0 || data_addr !== 16'h0 || data_din !== 16'h0 || memout !== 16'h0) begin
            errors++;
            $display("FAIL reset_state got rdy=%b req=%b rd=%b v=%b e=%b a=%h d=%h m=%h want 1 0 0 0 0 0 0 0",
                     req_ready, data_req, data_rd, rsp_valid, rsp_err, data_addr, data_din, memout);
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_ld();
        mem[int'(16'h3000)] = 16'h1234;
        run_req(0, 16'h3000, 16'h0, 0, 0, 0);
    endtask

    task automatic test_ldi();
        mem[int'(16'h3000)] = 16'h4000;
        mem[int'(16'h4000)] = 16'hBEEF;
        run_req(2, 16'h3000, 16'h0, 0, 0, 0);
    endtask

    task automatic test_sti();
        mem[int'(16'h3010)] = 16'h5000;
        run_req(3, 16'h3010, 16'h5555, 0, 0, 0);
        checks++;
        if (mrd(16'h5000) !== 16'h5555) begin
            errors++; $display("FAIL sti_write got=%h want=5555", mrd(16'h5000));
        end
    endtask

    task automatic test_wait_states();
        mem[int'(16'h2000)] = 16'h7E57;
        run_req(0, 16'h2000, 16'h0, 0, 3, 5);
        run_req(1, 16'h2100, 16'hA5A5, 0, 2, 1);
    endtask

    task automatic test_timeout();
        run_req(0, 16'h2222, 16'h0, 0, 255, 0);   // never acked
        run_req(0, 16'h2224, 16'h0, 0, 15, 0);    // ack in 16th cycle wins
        run_req(3, 16'h2226, 16'h1111, 16, 0, 2); // abort in IND, no ACC
        mem[int'(16'h2228)] = 16'hFFFF;
        run_req(2, 16'h2228, 16'h0, 15, 16, 0);   // pointer ok, access times out
    endtask

    task automatic test_reset_mid();
        log_addr.delete(); log_rd.delete(); log_din.delete();
        acc_idx = 0; dly[0] = 255; dly[1] = 255;
        req_valid = 1'b1; req_op = 2'd2; req_addr = 16'h3300;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (data_req !== 1'b1 || data_rd !== 1'b1 || data_addr !== 16'h3300) begin
            errors++; $display("FAIL mid_ind got req=%b rd=%b a=%h want 1 1 3300", data_req, data_rd, data_addr);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (data_req !== 1'b0 || req_ready !== 1'b1 || data_addr !== 16'h0 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL reset_mid got req=%b rdy=%b a=%h v=%b want 0 1 0000 0",
                               data_req, req_ready, data_addr, rsp_valid);
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        mem[int'(16'h3400)] = 16'hC0DE;
        run_req(0, 16'h3400, 16'h0, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        time t0, t1;
        run_req(0, 16'h0100, 16'h0, 0, 0, 0);
        t0 = last_accept;
        run_req(0, 16'h0101, 16'h0, 0, 0, 0);
        t1 = last_accept;
        checks++;
        if (t1 - t0 !== 30) begin
            errors++; $display("FAIL back_to_back got=%0t want=30", t1 - t0);
        end
        run_req(1, 16'h0102, 16'h4242, 0, 0, 0);
        t0 = last_accept;
        checks++;
        if (t0 - t1 !== 30) begin
            errors++; $display("FAIL back_to_back_st got=%0t want=30", t0 - t1);
        end
    endtask

    task automatic test_random();
        int dtab [10] = '{0, 0, 0, 1, 2, 3, 5, 14, 15, 20};
        int op, d1, d2;
        logic [15:0] a;
        noise = 1'b1;
        for (int k = 0; k < 40; k++) begin
            op = int'($urandom_range(0, 3));
            a  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            if (op >= 2 && $urandom_range(0, 3) == 0) mem[int'(a)] = 16'hFFFF;
            d1 = dtab[$urandom_range(0, 9)];
            d2 = dtab[$urandom_range(0, 9)];
            run_req(op, a, 16'($urandom), d1, d2, int'($urandom_range(0, 3)));
        end
        noise = 1'b0;
    endtask

    initial begin
        dly[0] = 0; dly[1] = 0;
        test_reset();
        test_ld();
        test_ldi();
        test_sti();
        test_wait_states();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lc3_memaccess_ctrl.md
# lc3_memaccess_ctrl

Sequencing controller for the LC3 MemAccess stage. It accepts one load/store request at a time from the pipeline controller and drives the data-memory port (data_addr, data_din, data_rd). It expands indirect operations (LDI/STI) into two memory accesses, tolerates wait states via an acknowledge handshake, and returns the load result on memout. An ack watchdog prevents a hung memory from stalling the pipeline indefinitely.

## Interface
Parameters:
- TIMEOUT, default 16: max cycles waiting for data_ack per access; 0 disables the watchdog.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller idle and able to accept.
- req_op  input  2  mem_op_t: LD=0, ST=1, LDI=2, STI=3.
- req_addr  input  16  effective address (pointer address for LDI/STI).
- req_data  input  16  store data (ST/STI); ignored for loads.
- data_req  output  1  memory access active.
- data_rd  output  1  1 = read, 0 = write; valid while data_req=1.
- data_addr  output  16  memory address.
- data_din  output  16  write data.
- data_dout  input  16  read data; sampled when data_req & data_ack.
- data_ack  input  1  access complete this cycle.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_err  output  1  watchdog fired for this request.
- memout  output  16  load result; 0 for stores and errors.

## Operation
- States: IDLE, IND, ACC, RSP (mem_state_t).
- IDLE: req_ready=1. On req_valid, latch op, addr_q=req_addr, data_q=req_data. Go to IND for LDI/STI, else to ACC.
- IND: data_req=1, data_rd=1, data_addr=addr_q.
  - On data_ack: addr_q <= data_dout; go to ACC.
- ACC: data_req=1, data_addr=addr_q.
  - data_rd=1 for LD/LDI. data_rd=0 for ST/STI, with data_din=data_q.
  - On data_ack: memout <= data_dout for loads, 0 for stores; go to RSP.
- RSP: rsp_valid=1. memout and rsp_err are held. On rsp_ready: clear rsp_err, go to IDLE.
- Outside ACC-store, data_din=0. Outside IND/ACC, data_req=0, data_rd=0, data_addr=0.
- data_ack is ignored when data_req=0.
- Watchdog (TIMEOUT>0):
  - wait_cnt clears on entry to IND/ACC and increments each cycle without ack.
  - If wait_cnt==TIMEOUT-1 and no ack: go to RSP with rsp_err=1 and memout=0. An LDI/STI aborted in IND skips ACC.
- Only one request is outstanding; req_valid is ignored outside IDLE.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE, so req_ready=1.
  - data_req, data_rd, rsp_valid, rsp_err = 0.
  - data_addr, data_din, memout = 0.
  - wait_cnt=0.
- Reset mid-access drops data_req in the same cycle. A pending memory write is abandoned.
- Zero-wait memory (ack in the first cycle of data_req), with request accepted at edge 0:
  - LD/ST: ACC during cycle 1; rsp_valid in cycle 2.
  - LDI/STI: IND in cycle 1, ACC in cycle 2, rsp_valid in cycle 3.
- Each wait state adds one cycle. data_addr, data_rd and data_din stay stable while data_req=1 and data_ack=0.
- Back-to-back: a new request can be accepted in the cycle after rsp_ready handshake (IDLE). Minimum LD throughput is 1 request per 3 cycles.
- If data_ack and the timeout coincide, ack wins (no error).
- Address width is 16 bits with no arithmetic. The indirect pointer is used verbatim, so xFFFF is legal.

## Structure
- Package memaccess_ctrl_pkg_hdl holds:
  - mem_op_t enum (LD, ST, LDI, STI).
  - mem_state_t enum (IDLE, IND, ACC, RSP).
  - Helper functions is_load(op) and is_indirect(op).
  - Localparam ADDR_W=16, DATA_W=16.
- Sub-module memaccess_wdog holds the watchdog:
  - Inputs: clock, reset, clear, active, ack.
  - Output: expire.
  - Counter width $clog2(TIMEOUT+1).
  - Generates constant expire=0 when TIMEOUT=0.
- Top holds the FSM and the addr_q/data_q/memout registers.

## Test plan
- LD: mem[x3000]=x1234, zero-wait ack, req at edge 0 -> one read of x3000 in cycle 1; rsp_valid in cycle 2 with memout=x1234, rsp_err=0.
- LDI: mem[x3000]=x4000, mem[x4000]=xBEEF -> reads x3000 then x4000; memout=xBEEF; rsp_valid in cycle 3.
- STI: mem[x3010]=x5000, req_data=x5555 -> read x3010, then write (data_rd=0, data_din=x5555) to x5000; memout=0.
- Wait states: LD x2000 with ack delayed 3 cycles -> data_addr=x2000 and data_rd=1 stable for 4 cycles; rsp_valid 3 cycles later than zero-wait. Additionally hold rsp_ready=0 for 5 cycles -> rsp_valid and memout held, req_ready=0.
- Timeout: TIMEOUT=16, ack never asserted on LD -> data_req high exactly 16 cycles, then rsp_valid=1, rsp_err=1, memout=0. Ack in the 16th cycle -> normal response, rsp_err=0.
- Reset asserted mid-IND of LDI -> data_req=0 and req_ready=1 in the same cycle. After deassert, a new LD completes normally.
